vga_console_m: RTL and testbench

Character-stream front end for the 80×60 text-mode VGA driver. It accepts bytes over a ready/valid interface, tracks a cursor and interprets a small set of control codes. It writes 16-bit cells into the driver's 32-bit text memory write port, using byte enables and `{attr,char,attr,char}` data. On line advance it wraps vertically and clears the new row; on reset or on request it clears the whole screen.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_console_m.sv | 170 +++++++++++++++++
 tb/tb_vga_console_m.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared geometry, control codes and state encoding for the 80x60 text console.
// Text memory holds two 16-bit cells per 32-bit word, 40 words per row.
package vga_pkg;

  localparam logic [6:0]  VGA_COLS      = 7'd80;
  localparam logic [5:0]  VGA_ROWS      = 6'd60;
  localparam logic [11:0] WORDS_PER_ROW = 12'd40;
  localparam logic [11:0] TEXT_WORDS    = 12'd2400;

  localparam logic [7:0] DEFAULT_ATTR = 8'h07;
  localparam logic [7:0] BLANK_CHAR   = 8'h20;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } console_state_e;

  // Two cells share a word, so the column contributes only its upper bits.
  function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return ({6'd0, row} * WORDS_PER_ROW) + ({5'd0, col} >> 1);
  endfunction

endpackage

// File: rtl/vga_console_m.sv
// Byte-stream console front end: cursor tracking, control codes and
// row/screen clears written into the text memory port of the VGA driver.
module vga_console_m
  import vga_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  input  logic        i_clear,
  input  logic        i_attr_we,
  input  logic [7:0]  i_attr,
  output logic [3:0]  o_vga_mem_we,
  output logic [11:0] o_vga_mem_waddr,
  output logic [31:0] o_vga_mem_wdata,
  output logic [6:0]  o_cursor_col,
  output logic [5:0]  o_cursor_row,
  output logic        o_busy
);

  console_state_e state_q, state_d;
  logic [11:0] clrCnt_q, clrCnt_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [7:0]  attr_q, attr_d;
  logic [7:0]  clrAttr_q, clrAttr_d;
  logic [3:0]  memWe_q, memWe_d;
  logic [11:0] memAddr_q, memAddr_d;
  logic [31:0] memData_q, memData_d;

  logic        rowAdvance;
  logic        glyphWrite;
  logic [5:0]  nextRow;
  logic [6:0]  tabCol;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLR_ALL;
      clrCnt_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      attr_q    <= DEFAULT_ATTR;
      clrAttr_q <= DEFAULT_ATTR;
      memWe_q   <= '0;
      memAddr_q <= '0;
      memData_q <= '0;
    end else begin
      state_q   <= state_d;
      clrCnt_q  <= clrCnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      attr_q    <= attr_d;
      clrAttr_q <= clrAttr_d;
      memWe_q   <= memWe_d;
      memAddr_q <= memAddr_d;
      memData_q <= memData_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clrCnt_d   = clrCnt_q;
    col_d      = col_q;
    row_d      = row_q;
    clrAttr_d  = clrAttr_q;
    memWe_d    = 4'h0;
    memAddr_d  = memAddr_q;
    memData_d  = memData_q;
    rowAdvance = 1'b0;
    glyphWrite = 1'b0;
    attr_d     = i_attr_we ? i_attr : attr_q;
    nextRow    = (row_q == VGA_ROWS - 6'd1) ? 6'd0 : row_q + 6'd1;
    tabCol     = (col_q | 7'd7) + 7'd1;

    case (state_q)
      IDLE: begin
        if (i_clear) begin
          state_d   = CLR_ALL;
          clrCnt_d  = '0;
          clrAttr_d = attr_q;
        end else if (i_valid) begin
          case (i_data)
            ASCII_CR: col_d = '0;
            ASCII_LF: begin
              col_d      = '0;
              rowAdvance = 1'b1;
            end
            ASCII_BS: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
            end
            ASCII_TAB: begin
              if (tabCol == VGA_COLS) begin
                col_d      = '0;
                rowAdvance = 1'b1;
              end else begin
                col_d = tabCol;
              end
            end
            default: begin
              glyphWrite = 1'b1;
              memWe_d    = col_q[0] ? 4'b1100 : 4'b0011;
              memAddr_d  = cell_addr(row_q, col_q);
              memData_d  = {attr_q, i_data, attr_q, i_data};
              if (col_q == VGA_COLS - 7'd1) begin
                col_d      = '0;
                rowAdvance = 1'b1;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
          endcase

          // Without a glyph occupying the write slot, the first clear word goes out immediately.
          if (rowAdvance) begin
            row_d     = nextRow;
            state_d   = CLR_ROW;
            clrAttr_d = attr_q;
            if (glyphWrite) begin
              clrCnt_d = '0;
            end else begin
              memWe_d   = 4'hF;
              memAddr_d = cell_addr(nextRow, 7'd0);
              memData_d = {attr_q, BLANK_CHAR, attr_q, BLANK_CHAR};
              clrCnt_d  = 12'd1;
            end
          end
        end
      end

      CLR_ROW: begin
        memWe_d   = 4'hF;
        memAddr_d = cell_addr(row_q, 7'd0) + clrCnt_q;
        memData_d = {clrAttr_q, BLANK_CHAR, clrAttr_q, BLANK_CHAR};
        clrCnt_d  = clrCnt_q + 12'd1;
        if (clrCnt_q == WORDS_PER_ROW - 12'd1) begin
          state_d  = IDLE;
          clrCnt_d = '0;
        end
      end

      CLR_ALL: begin
        memWe_d   = 4'hF;
        memAddr_d = clrCnt_q;
        memData_d = {clrAttr_q, BLANK_CHAR, clrAttr_q, BLANK_CHAR};
        clrCnt_d  = clrCnt_q + 12'd1;
        if (clrCnt_q == TEXT_WORDS - 12'd1) begin
          state_d  = IDLE;
          clrCnt_d = '0;
          col_d    = '0;
          row_d    = '0;
        end
      end

      default: begin
        state_d  = CLR_ALL;
        clrCnt_d = '0;
      end
    endcase
  end

  assign o_ready         = (state_q == IDLE);
  assign o_busy          = (state_q != IDLE);
  assign o_vga_mem_we    = memWe_q;
  assign o_vga_mem_waddr = memAddr_q;
  assign o_vga_mem_wdata = memData_q;
  assign o_cursor_col    = col_q;
  assign o_cursor_row    = row_q;

endmodule

// File: tb/tb_vga_console_m.sv
// Directed bench for vga_console_m: expected text-memory writes are queued as
// bytes are issued and a negedge monitor pops and compares every DUT write.
module tb_vga_console_m;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_ready;
  logic        i_clear;
  logic        i_attr_we;
  logic [7:0]  i_attr;
  logic [3:0]  o_vga_mem_we;
  logic [11:0] o_vga_mem_waddr;
  logic [31:0] o_vga_mem_wdata;
  logic [6:0]  o_cursor_col;
  logic [5:0]  o_cursor_row;
  logic        o_busy;

  typedef struct packed {
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  wr_t         monE;
  logic [31:0] monMask;
  int          checks = 0;
  int          errors = 0;

  vga_console_m dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .i_clear        (i_clear),
    .i_attr_we      (i_attr_we),
    .i_attr         (i_attr),
    .o_vga_mem_we   (o_vga_mem_we),
    .o_vga_mem_waddr(o_vga_mem_waddr),
    .o_vga_mem_wdata(o_vga_mem_wdata),
    .o_cursor_col   (o_cursor_col),
    .o_cursor_row   (o_cursor_row),
    .o_busy         (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Only the enabled bytes of a write carry meaning, so data is compared under the enables.
  always @(negedge i_clk) begin
    if (o_vga_mem_we != 4'h0) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got we=%h addr=%0d data=%h, required no write",
                 o_vga_mem_we, o_vga_mem_waddr, o_vga_mem_wdata);
      end else begin
        monE    = expQ.pop_front();
        monMask = {{8{monE.we[3]}}, {8{monE.we[2]}}, {8{monE.we[1]}}, {8{monE.we[0]}}};
        if (o_vga_mem_we !== monE.we || o_vga_mem_waddr !== monE.addr ||
            (o_vga_mem_wdata & monMask) !== (monE.data & monMask)) begin
          errors++;
          $display("[TB] FAIL mem_write: got we=%h addr=%0d data=%h, required we=%h addr=%0d data=%h",
                   o_vga_mem_we, o_vga_mem_waddr, o_vga_mem_wdata, monE.we, monE.addr, monE.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expectWrite(input logic [3:0] we, input logic [11:0] addr, input logic [31:0] data);
    expQ.push_back({we, addr, data});
  endtask

  task automatic expectClear(input logic [11:0] base, input int n, input logic [7:0] attr);
    for (int i = 0; i < n; i++) expectWrite(4'hF, base + 12'(i), {attr, 8'h20, attr, 8'h20});
  endtask

  task automatic expectGlyph(input logic [5:0] row, input logic [6:0] col,
                             input logic [7:0] attr, input logic [7:0] ch);
    expectWrite(col[0] ? 4'hC : 4'h3, 12'(row) * 12'd40 + 12'(col >> 1), {attr, ch, attr, ch});
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (o_ready !== 1'b1 && n < 6000) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (o_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got o_ready=%b, required 1 within 6000 cycles", name, o_ready);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    waitReady("send");
    i_valid = 1'b1;
    i_data  = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic setAttr(input logic [7:0] a);
    i_attr_we = 1'b1;
    i_attr    = a;
    @(posedge i_clk); #1;
    i_attr_we = 1'b0;
  endtask

  task automatic drainWrites(input string name);
    waitReady(name);
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    checkOutput({name, "_pending"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00;
    i_clear = 1'b0; i_attr_we = 1'b0; i_attr = 8'h00;

    // Reset state and the full-screen clear that follows release.
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_we", 32'(o_vga_mem_we), 32'd0);
    checkOutput("rst_waddr", 32'(o_vga_mem_waddr), 32'd0);
    checkOutput("rst_wdata", o_vga_mem_wdata, 32'd0);
    checkOutput("rst_col", 32'(o_cursor_col), 32'd0);
    checkOutput("rst_row", 32'(o_cursor_row), 32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd0);
    expectClear(12'd0, 2400, 8'h07);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("busy_after_rst", 32'(o_busy), 32'd1);
    checkOutput("ready_after_rst", 32'(o_ready), 32'd0);
    drainWrites("reset_clear");
    checkOutput("ready_idle", 32'(o_ready), 32'd1);
    checkOutput("clear_col", 32'(o_cursor_col), 32'd0);
    checkOutput("clear_row", 32'(o_cursor_row), 32'd0);

    // Glyph placement with a new attribute, back to back.
    setAttr(8'h1E);
    expectGlyph(6'd0, 7'd0, 8'h1E, 8'h41);
    expectGlyph(6'd0, 7'd1, 8'h1E, 8'h42);
    applyStimulus(8'h41);
    checkOutput("glyph_ready_back2back", 32'(o_ready), 32'd1);
    applyStimulus(8'h42);
    checkOutput("glyph_col", 32'(o_cursor_col), 32'd2);
    drainWrites("glyph");

    // Full row of glyphs wraps into row 1 and clears it.
    applyStimulus(8'h0D);
    checkOutput("cr_col", 32'(o_cursor_col), 32'd0);
    for (int i = 0; i < 80; i++) expectGlyph(6'd0, 7'(i), 8'h1E, 8'h61 + 8'(i % 26));
    expectClear(12'd40, 40, 8'h1E);
    for (int i = 0; i < 80; i++) applyStimulus(8'h61 + 8'(i % 26));
    drainWrites("line_wrap");
    checkOutput("wrap_col", 32'(o_cursor_col), 32'd0);
    checkOutput("wrap_row", 32'(o_cursor_row), 32'd1);

    // Control codes move the cursor without touching memory.
    for (int i = 0; i < 5; i++) expectGlyph(6'd1, 7'(i), 8'h1E, 8'h78);
    for (int i = 0; i < 5; i++) applyStimulus(8'h78);
    checkOutput("ctl_start_col", 32'(o_cursor_col), 32'd5);
    applyStimulus(8'h08);
    checkOutput("bs_col", 32'(o_cursor_col), 32'd4);
    applyStimulus(8'h09);
    checkOutput("tab_col", 32'(o_cursor_col), 32'd8);
    applyStimulus(8'h0D);
    checkOutput("cr_col2", 32'(o_cursor_col), 32'd0);
    applyStimulus(8'h08);
    checkOutput("bs_at_zero", 32'(o_cursor_col), 32'd0);
    drainWrites("controls");
    checkOutput("ctl_row", 32'(o_cursor_row), 32'd1);

    // Tab from column 72 lands on 80 and wraps to the next row.
    for (int i = 0; i < 9; i++) applyStimulus(8'h09);
    checkOutput("tab_72", 32'(o_cursor_col), 32'd72);
    expectClear(12'd80, 40, 8'h1E);
    applyStimulus(8'h09);
    drainWrites("tab_wrap");
    checkOutput("tab_wrap_col", 32'(o_cursor_col), 32'd0);
    checkOutput("tab_wrap_row", 32'(o_cursor_row), 32'd2);

    // Line feeds down to the last row, then wrap back to row 0.
    for (int r = 3; r < 60; r++) begin
      expectClear(12'(r * 40), 40, 8'h1E);
      applyStimulus(8'h0A);
    end
    drainWrites("lf_walk");
    checkOutput("row59", 32'(o_cursor_row), 32'd59);
    setAttr(8'h2C);
    expectClear(12'd0, 40, 8'h2C);
    applyStimulus(8'h0A);
    checkOutput("bottom_busy", 32'(o_busy), 32'd1);
    drainWrites("bottom_wrap");
    checkOutput("bottom_col", 32'(o_cursor_col), 32'd0);
    checkOutput("bottom_row", 32'(o_cursor_row), 32'd0);

    // Clear request beats a simultaneous byte; the byte lands after the clear.
    expectGlyph(6'd0, 7'd0, 8'h2C, 8'h51);
    applyStimulus(8'h51);
    drainWrites("pre_clear");
    expectClear(12'd0, 2400, 8'h2C);
    expectGlyph(6'd0, 7'd0, 8'h2C, 8'h5A);
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h5A;
    @(posedge i_clk); #1;
    i_clear = 1'b0;
    checkOutput("prio_busy", 32'(o_busy), 32'd1);
    checkOutput("prio_not_accepted", 32'(o_cursor_col), 32'd1);
    waitReady("clear_all");
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checkOutput("prio_col", 32'(o_cursor_col), 32'd1);
    checkOutput("prio_row", 32'(o_cursor_row), 32'd0);
    drainWrites("priority");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
